inverted_bit_deserializer: RTL and testbench

Receive-side counterpart of the registered bit inverter. Samples an inverted serial line, re-inverts each bit, frames it with a start bit and a stop bit, and assembles WIDTH-bit words. Completed words go to a downstream consumer over a single-entry valid/ready output register. Same clock domain as the transmitting inverter stage, so no input synchronizer is used.

---
 rtl/inverted_bit_deserializer.sv | 127 ++++++++++++
 tb/tb_inverted_bit_deserializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverted_bit_deserializer.sv
// Start/stop framed deserializer for an inverted serial line; word appears 1 clock after the stop sample.
// Single-entry output register: a word completing while it is still full is dropped and flags sticky overflow.
module inverted_bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             framing_error,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             framing_error_q, framing_error_d;
    logic             overflow_q, overflow_d;

    logic             d_bit;
    logic             stop_good;
    logic             deliver;
    int unsigned      bit_pos;

    assign d_bit = ~line_in;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        sr_d            = sr_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q;
        framing_error_d = 1'b0;
        overflow_d      = overflow_q;
        stop_good       = 1'b0;
        deliver         = 1'b0;
        bit_pos         = LSB_FIRST ? 32'(cnt_q) : 32'(WIDTH - 1) - 32'(cnt_q);

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (d_bit) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (bit_pos == i) begin
                            sr_d[i] = d_bit;
                        end
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (d_bit) begin
                        framing_error_d = 1'b1;
                    end else begin
                        stop_good = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A consumer pop in the same cycle frees the register for the new word.
        if (stop_good) begin
            if (!out_valid_q || out_ready) begin
                deliver = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (deliver) begin
            out_data_d  = sr_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            sr_q            <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            framing_error_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sr_q            <= sr_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            framing_error_q <= framing_error_d;
            overflow_q      <= overflow_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign framing_error = framing_error_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_inverted_bit_deserializer.sv
// Scenario bench for inverted_bit_deserializer: scoreboard of expected words, popped on each handshake.
module tb_inverted_bit_deserializer;
    localparam int W   = 8;
    localparam bit LSB = 1'b1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         line_in = 1'b1;
    logic         bit_en = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         framing_error;
    logic         overflow;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic         hold_prev = 1'b0;
    logic [W-1:0] held;

    inverted_bit_deserializer #(.WIDTH(W), .LSB_FIRST(LSB)) dut (
        .clk(clk),
        .rst(rst),
        .line_in(line_in),
        .bit_en(bit_en),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .framing_error(framing_error),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Consumer-side scoreboard and stability check, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_prev && out_valid) begin
                vectors++;
                if (out_data !== held) begin
                    miscompares++;
                    $display("FAIL hold_stable: out_data=%h required %h", out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: out_data=%h required no word", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        miscompares++;
                        $display("FAIL word: out_data=%h required %h", out_data, e);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            held      = out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Apply inputs for one cycle; returns 1 time unit after the edge that consumed them.
    task automatic step(input logic ln, input logic en);
        line_in = ln;
        bit_en  = en;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        exp_q.delete();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic stop_ok,
                              input int stride, input logic ready_at_stop);
        logic b;
        for (int k = 1; k < stride; k++) step(1'($urandom), 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < W; i++) begin
            b = LSB ? word[i] : word[W-1-i];
            for (int k = 1; k < stride; k++) step(1'($urandom), 1'b0);
            step(~b, 1'b1);
        end
        for (int k = 1; k < stride; k++) step(1'($urandom), 1'b0);
        if (ready_at_stop) out_ready = 1'b1;
        step(stop_ok, 1'b1);
        bit_en  = 1'b0;
        line_in = 1'b1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({out_data, out_valid, framing_error, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: outputs=%h required 0", {out_data, out_valid, framing_error, overflow});
        end
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b1);
            vectors++;
            if ({out_data, out_valid, framing_error, overflow} !== '0) begin
                miscompares++;
                $display("FAIL idle_line cycle %0d: outputs=%h required 0", c,
                         {out_data, out_valid, framing_error, overflow});
            end
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_latency: valid=%b data=%h required 1 a5", out_valid, out_data);
        end
        step(1'b1, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_one_cycle: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_strobe_glitch();
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 3, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL strobe_glitch: valid=%b data=%h required 1 a5", out_valid, out_data);
        end
        step(1'b1, 1'b0);
    endtask

    task automatic test_framing();
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1, 1'b0);
        vectors++;
        if (framing_error !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL framing_pulse: ferr=%b valid=%b required 1 0", framing_error, out_valid);
        end
        step(1'b1, 1'b1);
        vectors++;
        if (framing_error !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL framing_clear: ferr=%b valid=%b required 0 0", framing_error, out_valid);
        end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || framing_error !== 1'b0) begin
            miscompares++;
            $display("FAIL framing_recover: valid=%b data=%h ferr=%b required 1 3c 0",
                     out_valid, out_data, framing_error);
        end
        step(1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b1, 1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: valid=%b data=%h ovf=%b required 1 11 1", out_valid, out_data, overflow);
        end
        out_ready = 1'b1;
        step(1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_drain: valid=%b ovf=%b required 0 1", out_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        out_ready = 1'b0;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1, 1'b0);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_load: valid=%b data=%h ovf=%b required 1 77 0",
                     out_valid, out_data, overflow);
        end
        step(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        vectors++;
        if ({out_data, out_valid, framing_error, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_frame: outputs=%h required 0", {out_data, out_valid, framing_error, overflow});
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL after_reset_frame: valid=%b data=%h required 1 5a", out_valid, out_data);
        end
        step(1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe_glitch();
        test_framing();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        step(1'b1, 1'b0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d words outstanding required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
